// File: rtl/platform_spawner.sv
// platform_spawner: draws random platform positions (x from a rejection-sampled
// LFSR value, y as a random gap below the previous platform) and queues them in
// a small show-ahead FIFO for the consumer.
module platform_spawner #(
  parameter int X_MAX     = 447,
  parameter int X_OFFSET  = 32,
  parameter int GAP_MIN   = 40,
  parameter int MAX_TRIES = 8,
  parameter int DEPTH     = 4,
  parameter int Y_START   = 460
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [8:0] rnd,
  input  logic       spawn_req,
  input  logic       pop,
  output logic [9:0] plat_x,
  output logic [9:0] plat_y,
  output logic       plat_valid,
  output logic       full,
  output logic       busy,
  output logic [2:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAW_X   = 2'd1,
    DRAW_GAP = 2'd2,
    PUSH     = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [TRY_W-1:0] tries_r, tries_nxt_s;
  logic [9:0]       cand_x_r, cand_x_nxt_s;
  logic [9:0]       cand_y_r, cand_y_nxt_s;
  logic [9:0]       last_y_r, last_y_nxt_s;
  logic [6:0]       gap_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             valid_s;

  logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r;
  logic [2:0]       count_r;
  logic [9:0]       x_mem_r [DEPTH];
  logic [9:0]       y_mem_r [DEPTH];

  // Pointer advance with explicit wrap so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // The gap always uses the value present during DRAW_GAP, not the x draw.
  assign gap_s   = 7'(GAP_MIN) + {2'b00, rnd[4:0]};
  assign full_s  = (count_r == 3'(DEPTH));
  assign valid_s = (count_r != 3'd0);
  // A pop on an empty queue is simply dropped.
  assign pop_s   = pop && valid_s;

  // Next-state and datapath decisions for the draw sequence.
  always_comb begin
    state_nxt_s  = state_r;
    tries_nxt_s  = tries_r;
    cand_x_nxt_s = cand_x_r;
    cand_y_nxt_s = cand_y_r;
    last_y_nxt_s = last_y_r;
    push_s       = 1'b0;
    case (state_r)
      IDLE: begin
        // Requests while full are dropped, which guarantees PUSH never overflows.
        if (spawn_req && !full_s) begin
          state_nxt_s = DRAW_X;
          tries_nxt_s = {TRY_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAW_X: begin
        if ({1'b0, rnd} <= 10'(X_MAX)) begin
          cand_x_nxt_s = {1'b0, rnd} + 10'(X_OFFSET);
          state_nxt_s  = DRAW_GAP;
        end else if (tries_r == TRY_W'(MAX_TRIES)) begin
          // Out of retries: fold the out-of-range value back into range.
          cand_x_nxt_s = {1'b0, rnd} - 10'(X_MAX + 1) + 10'(X_OFFSET);
          state_nxt_s  = DRAW_GAP;
        end else begin
          tries_nxt_s  = tries_r + TRY_W'(1);
          state_nxt_s  = DRAW_X;
        end
      end
      DRAW_GAP: begin
        if (last_y_r >= {3'b000, gap_s}) begin
          cand_y_nxt_s = last_y_r - {3'b000, gap_s};
        end else begin
          cand_y_nxt_s = 10'(Y_START);
        end
        state_nxt_s = PUSH;
      end
      PUSH: begin
        push_s       = 1'b1;
        last_y_nxt_s = cand_y_r;
        state_nxt_s  = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Draw FSM state, retry counter and candidate registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r  <= IDLE;
      tries_r  <= {TRY_W{1'b0}};
      cand_x_r <= 10'd0;
      cand_y_r <= 10'd0;
      last_y_r <= 10'(Y_START);
    end else begin
      state_r  <= state_nxt_s;
      tries_r  <= tries_nxt_s;
      cand_x_r <= cand_x_nxt_s;
      cand_y_r <= cand_y_nxt_s;
      last_y_r <= last_y_nxt_s;
    end
  end

  // Queue storage, pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        x_mem_r[i] <= 10'd0;
        y_mem_r[i] <= 10'd0;
      end
    end else begin
      if (push_s) begin
        x_mem_r[wr_ptr_r] <= cand_x_r;
        y_mem_r[wr_ptr_r] <= cand_y_r;
        wr_ptr_r          <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign plat_valid = valid_s;
  assign full       = full_s;
  assign busy       = (state_r != IDLE);
  assign count      = count_r;
  assign plat_x     = valid_s ? x_mem_r[rd_ptr_r] : 10'd0;
  assign plat_y     = valid_s ? y_mem_r[rd_ptr_r] : 10'd0;

endmodule

// File: tb/tb_platform_spawner.sv
// Directed self-checking bench for platform_spawner.
module tb_platform_spawner;

  logic       Clk;
  logic       Reset;
  logic [8:0] rnd;
  logic       spawn_req;
  logic       pop;
  logic [9:0] plat_x;
  logic [9:0] plat_y;
  logic       plat_valid;
  logic       full;
  logic       busy;
  logic [2:0] count;

  int n_cmp = 0;
  int n_bad = 0;
  int nb;
  int exp_y [7] = '{389, 318, 247, 176, 105, 34, 460};

  platform_spawner dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .rnd        (rnd),
    .spawn_req  (spawn_req),
    .pop        (pop),
    .plat_x     (plat_x),
    .plat_y     (plat_y),
    .plat_valid (plat_valid),
    .full       (full),
    .busy       (busy),
    .count      (count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  // One spawn: nrej reject values, then acc in DRAW_X, then grnd for DRAW_GAP.
  // Optionally pops during the PUSH cycle. Returns the number of busy cycles.
  task automatic spawn(input logic [8:0] rej, input int nrej, input logic [8:0] acc,
                       input logic [8:0] grnd, input logic pop_push, output int nbusy);
    spawn_req = 1'b1;
    rnd = 9'h000;
    step();
    spawn_req = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      pop = 1'b0;
      if (!busy) break;
      nbusy++;
      rnd = (i < nrej) ? rej : ((i == nrej) ? acc : grnd);
      pop = pop_push && (i == nrej + 2);
      step();
    end
    pop = 1'b0;
    chk("spawn_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    Reset = 1'b0;
    rnd = 9'h000;
    spawn_req = 1'b0;
    pop = 1'b0;
    repeat (2) step();
    chk("rst_valid", {31'd0, plat_valid}, 32'd0);
    chk("rst_full",  {31'd0, full}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_x",     {22'd0, plat_x}, 32'd0);
    chk("rst_y",     {22'd0, plat_y}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    Reset = 1'b1;

    // Basic spawn, edge-by-edge latency.
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    rnd = 9'h010;
    chk("lat_busy_k", {31'd0, busy}, 32'd1);
    step();
    rnd = 9'h005;
    chk("lat_valid_k1", {31'd0, plat_valid}, 32'd0);
    step();
    chk("lat_valid_k2", {31'd0, plat_valid}, 32'd0);
    step();
    chk("lat_valid_k3", {31'd0, plat_valid}, 32'd1);
    chk("basic_x", {22'd0, plat_x}, 32'd48);
    chk("basic_y", {22'd0, plat_y}, 32'd415);
    chk("basic_busy", {31'd0, busy}, 32'd0);
    chk("basic_count", {29'd0, count}, 32'd1);
    do_pop();
    chk("pop_count", {29'd0, count}, 32'd0);
    chk("pop_valid", {31'd0, plat_valid}, 32'd0);
    chk("pop_x", {22'd0, plat_x}, 32'd0);
    do_pop();
    chk("pop_empty_count", {29'd0, count}, 32'd0);

    // Rejects: three then accept; then fallback after exhausting retries.
    spawn(9'h1F0, 3, 9'h064, 9'h005, 1'b0, nb);
    chk("rej3_busy", nb, 32'd6);
    chk("rej3_x", {22'd0, plat_x}, 32'd132);
    chk("rej3_y", {22'd0, plat_y}, 32'd370);
    spawn(9'h1FF, 8, 9'h1FF, 9'h005, 1'b0, nb);
    chk("fb_busy", nb, 32'd11);
    chk("fb_head_x", {22'd0, plat_x}, 32'd132);
    chk("fb_count", {29'd0, count}, 32'd2);
    do_pop();
    chk("fb_x", {22'd0, plat_x}, 32'd95);
    chk("fb_y", {22'd0, plat_y}, 32'd325);
    do_pop();

    // Fill the queue, ignored request, concurrent push and pop.
    for (int i = 0; i < 4; i++) spawn(9'h000, 0, 9'h000, 9'h000, 1'b0, nb);
    chk("fill_count", {29'd0, count}, 32'd4);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_head_y", {22'd0, plat_y}, 32'd285);
    spawn(9'h000, 0, 9'h000, 9'h000, 1'b0, nb);
    chk("full_ignored_busy", nb, 32'd0);
    chk("full_ignored_count", {29'd0, count}, 32'd4);
    do_pop();
    chk("unfull_count", {29'd0, count}, 32'd3);
    chk("unfull_full", {31'd0, full}, 32'd0);
    chk("unfull_head_y", {22'd0, plat_y}, 32'd245);
    spawn(9'h000, 0, 9'h000, 9'h000, 1'b1, nb);
    chk("pushpop_count", {29'd0, count}, 32'd3);
    chk("pushpop_head_y", {22'd0, plat_y}, 32'd205);
    do_pop();
    chk("order_y1", {22'd0, plat_y}, 32'd165);
    do_pop();
    chk("order_y2", {22'd0, plat_y}, 32'd125);
    do_pop();
    chk("order_empty", {29'd0, count}, 32'd0);

    // Fresh reset, then seven maximum gaps walking down to the wrap.
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      spawn(9'h000, 0, 9'h000, 9'h01F, 1'b0, nb);
      chk($sformatf("wrap_y%0d", i), {22'd0, plat_y}, exp_y[i]);
      do_pop();
    end

    // Reset in the middle of a draw with one entry queued.
    spawn(9'h000, 0, 9'h000, 9'h000, 1'b0, nb);
    chk("mid_pre_y", {22'd0, plat_y}, 32'd420);
    chk("mid_pre_count", {29'd0, count}, 32'd1);
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    rnd = 9'h010;
    step();
    chk("mid_in_draw", {31'd0, busy}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("mid_count", {29'd0, count}, 32'd0);
    chk("mid_valid", {31'd0, plat_valid}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_x", {22'd0, plat_x}, 32'd0);
    step();
    Reset = 1'b1;
    spawn(9'h000, 0, 9'h010, 9'h005, 1'b0, nb);
    chk("post_rst_busy", nb, 32'd3);
    chk("post_rst_count", {29'd0, count}, 32'd1);
    chk("post_rst_x", {22'd0, plat_x}, 32'd48);
    chk("post_rst_y", {22'd0, plat_y}, 32'd415);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
